noc_cpu_mult_pipe: RTL and testbench

- Parametrised, pipelined integer multiply unit for the NOC CPU datapath.
- Successor to the fixed 32-bit three-partial-product multiplier cell. Adds:
  - configurable operand width;
  - full 2×DATA_W product with RISC-style low/high result selection and signed/unsigned operand modes;
  - valid/ready handshakes with backpressure;
  - a sideband tag carried alongside each operation.
- Sits between the execute stage and the writeback arbiter.

---
 rtl/noc_mult_pkg.sv | 23 ++
 rtl/noc_mult_pp_cell.sv | 28 ++
 rtl/noc_cpu_mult_pipe.sv | 138 +++++++++++++
 tb/tb_noc_cpu_mult_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_mult_pkg.sv
// Shared types and helpers for the NOC CPU multiply unit.
// Operation encodings follow the RISC-V M-extension multiply group.
package noc_mult_pkg;

  localparam int OP_W       = 2;
  localparam int PIPE_DEPTH = 2;

  typedef enum logic [OP_W-1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mult_op_t;

  function automatic logic op_a_signed(mult_op_t op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic op_b_signed(mult_op_t op);
    return (op == MULH);
  endfunction

endpackage

// File: rtl/noc_mult_pp_cell.sv
// Registered HALF_W x HALF_W unsigned partial-product multiplier with
// clock enable and synchronous clear.
module noc_mult_pp_cell #(
  parameter int HALF_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [HALF_W-1:0]   a,
  input  logic [HALF_W-1:0]   b,
  output logic [2*HALF_W-1:0] p
);

  logic [2*HALF_W-1:0] a_ext;
  logic [2*HALF_W-1:0] b_ext;

  assign a_ext = {{HALF_W{1'b0}}, a};
  assign b_ext = {{HALF_W{1'b0}}, b};

  always_ff @(posedge clk) begin
    if (reset) begin
      p <= '0;
    end else if (en) begin
      p <= a_ext * b_ext;
    end
  end

endmodule

// File: rtl/noc_cpu_mult_pipe.sv
// Two-stage pipelined integer multiplier with valid/ready flow control and tag.
// Define NOC_MULT_FULL_PRODUCT_EN for MULH/MULHSU/MULHU; otherwise only MUL (low bits).
module noc_cpu_mult_pipe
  import noc_mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PROD_W = 2 * DATA_W;

  logic              adv;
  logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;

  logic              vld_p1;
  logic [TAG_W-1:0]  tag_p1;
  logic [DATA_W-1:0] pp_ll_p1, pp_lh_p1, pp_hl_p1;

  logic [DATA_W-1:0] result_d;

  logic              vld_p2;
  logic [TAG_W-1:0]  tag_p2;
  logic [DATA_W-1:0] result_p2;

  // One advance signal moves the whole pipe; bubbles are kept, not squeezed.
  assign adv      = ~vld_p2 | out_ready;
  assign in_ready = adv;

  assign a_lo = in_a[HALF_W-1:0];
  assign a_hi = in_a[DATA_W-1:HALF_W];
  assign b_lo = in_b[HALF_W-1:0];
  assign b_hi = in_b[DATA_W-1:HALF_W];

  // ---- stage 1: partial products, sign corrections, op/tag ----
  noc_mult_pp_cell #(.HALF_W(HALF_W)) u_pp_ll (
    .clk(clk), .reset(reset), .en(adv), .a(a_lo), .b(b_lo), .p(pp_ll_p1)
  );

  noc_mult_pp_cell #(.HALF_W(HALF_W)) u_pp_lh (
    .clk(clk), .reset(reset), .en(adv), .a(a_lo), .b(b_hi), .p(pp_lh_p1)
  );

  noc_mult_pp_cell #(.HALF_W(HALF_W)) u_pp_hl (
    .clk(clk), .reset(reset), .en(adv), .a(a_hi), .b(b_lo), .p(pp_hl_p1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      tag_p1 <= '0;
    end else if (adv) begin
      vld_p1 <= in_valid;
      tag_p1 <= in_tag;
    end
  end

`ifdef NOC_MULT_FULL_PRODUCT_EN
  mult_op_t          op_in;
  mult_op_t          op_p1;
  logic [DATA_W-1:0] pp_hh_p1;
  logic [DATA_W-1:0] corr_a_p1, corr_b_p1;
  logic [PROD_W-1:0] prod;
  logic [DATA_W-1:0] prod_hi;
  logic [DATA_W-1:0] hi;

  function automatic logic [DATA_W-1:0] select_result(
    input mult_op_t          op,
    input logic [DATA_W-1:0] lo_bits,
    input logic [DATA_W-1:0] hi_bits
  );
    return (op == MUL) ? lo_bits : hi_bits;
  endfunction

  assign op_in = mult_op_t'(in_op);

  noc_mult_pp_cell #(.HALF_W(HALF_W)) u_pp_hh (
    .clk(clk), .reset(reset), .en(adv), .a(a_hi), .b(b_hi), .p(pp_hh_p1)
  );

  // A negative signed operand adds 2^DATA_W * other to the unsigned product,
  // so the other operand is subtracted from the high half afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_p1     <= MUL;
      corr_a_p1 <= '0;
      corr_b_p1 <= '0;
    end else if (adv) begin
      op_p1     <= op_in;
      corr_a_p1 <= (op_a_signed(op_in) && in_a[DATA_W-1]) ? in_b : '0;
      corr_b_p1 <= (op_b_signed(op_in) && in_b[DATA_W-1]) ? in_a : '0;
    end
  end

  assign prod     = {pp_hh_p1, pp_ll_p1}
                  + (PROD_W'(pp_lh_p1) << HALF_W)
                  + (PROD_W'(pp_hl_p1) << HALF_W);
  assign prod_hi  = prod[PROD_W-1:DATA_W];
  assign hi       = prod_hi - corr_a_p1 - corr_b_p1;
  assign result_d = select_result(op_p1, prod[DATA_W-1:0], hi);
`else
  logic unused_op;

  assign unused_op = ^in_op;
  assign result_d  = pp_ll_p1 + (pp_lh_p1 << HALF_W) + (pp_hl_p1 << HALF_W);
`endif

  // ---- stage 2: product sum, result select ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2    <= 1'b0;
      tag_p2    <= '0;
      result_p2 <= '0;
    end else if (adv) begin
      vld_p2    <= vld_p1;
      tag_p2    <= tag_p1;
      result_p2 <= result_d;
    end
  end

  assign out_valid  = vld_p2;
  assign out_result = result_p2;
  assign out_tag    = tag_p2;

endmodule

// File: tb/tb_noc_cpu_mult_pipe.sv
// Scoreboard bench for noc_cpu_mult_pipe: directed vectors, decoupled monitor.
module tb_noc_cpu_mult_pipe;
  import noc_mult_pkg::*;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int NV     = 11;
`ifdef NOC_MULT_FULL_PRODUCT_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OP_W-1:0]   in_op = '0;
  logic [DATA_W-1:0] in_a = '0;
  logic [DATA_W-1:0] in_b = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;

  always #5 clk = ~clk;

  noc_cpu_mult_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  typedef struct {
    logic [DATA_W-1:0] res;
    logic [TAG_W-1:0]  tag;
  } exp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] full;
    logic [31:0] lo;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[NV];
  int   total = 0;
  int   bad = 0;
  int   retired = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] full, input logic [31:0] lo);
    return FULL ? full : lo;
  endfunction

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] res);
    exp_t e;
    bit   acc;
    bit   done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    for (int k = 0; k < 50 && !done; k++) begin
      #1 acc = in_ready;
      @(posedge clk);
      if (acc) begin
        e.res = res; e.tag = tag;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every completed output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got tag %0h result %0h, expected none", out_tag, out_result);
        end else begin
          e = sb.pop_front();
          chk("result", 64'(out_result), 64'(e.res));
          chk("tag", 64'(out_tag), 64'(e.tag));
          retired++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    int base;
    int seen;

    vecs[0]  = '{2'd0, 32'd7,         32'd6,         32'd42,        32'd42};
    vecs[1]  = '{2'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  32'h00000001};
    vecs[2]  = '{2'd0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  32'h00000001};
    vecs[3]  = '{2'd1, 32'h80000000,  32'h80000000,  32'h40000000,  32'h00000000};
    vecs[4]  = '{2'd1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  32'h00000001};
    vecs[5]  = '{2'd2, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFE};
    vecs[6]  = '{2'd3, 32'hFFFFFFFF,  32'd2,         32'h00000001,  32'hFFFFFFFE};
    vecs[7]  = '{2'd1, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFE};
    vecs[8]  = '{2'd2, 32'd2,         32'hFFFFFFFF,  32'h00000001,  32'hFFFFFFFE};
    vecs[9]  = '{2'd0, 32'h12345678,  32'h00000010,  32'h23456780,  32'h23456780};
    vecs[10] = '{2'd1, 32'h7FFFFFFF,  32'h7FFFFFFF,  32'h3FFFFFFF,  32'h00000001};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_result", 64'(out_result), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);

    // Single MUL: empty one edge after accept, valid the next.
    send(vecs[0].op, vecs[0].a, vecs[0].b, 5'd3, pick(vecs[0].full, vecs[0].lo));
    idle();
    #1 chk("lat_s1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("lat_s2_valid", 64'(out_valid), 64'd1);
    chk("lat_s2_result", 64'(out_result), 64'd42);
    chk("lat_s2_tag", 64'(out_tag), 64'd3);
    drain("drain_single");

    // Back-to-back stream of all op types at full throughput.
    send(vecs[1].op, vecs[1].a, vecs[1].b, 5'd4, pick(vecs[1].full, vecs[1].lo));
    t0 = cyc;
    for (int i = 2; i < NV; i++)
      send(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 3), pick(vecs[i].full, vecs[i].lo));
    t1 = cyc;
    idle();
    chk("throughput_cycles", 64'(t1 - t0), 64'(NV - 2));
    drain("drain_stream");

    // Backpressure: hold out_ready low for 3 cycles at the second result.
    base = retired;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(2'd0, 32'(i + 1), 32'd100, 5'(20 + i), 32'((i + 1) * 100));
        idle();
      end
      begin
        bit stalled;
        stalled = 1'b0;
        for (int k = 0; k < 40 && !stalled; k++) begin
          @(negedge clk);
          if (out_valid && retired == base + 1) begin
            out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
              #1;
              chk("bp_in_ready_low", 64'(in_ready), 64'd0);
              chk("bp_hold_valid", 64'(out_valid), 64'd1);
              chk("bp_hold_result", 64'(out_result), 64'd200);
              chk("bp_hold_tag", 64'(out_tag), 64'd21);
              @(negedge clk);
            end
            out_ready = 1'b1;
            stalled = 1'b1;
          end
        end
        if (!stalled) chk("bp_stall_reached", 64'd0, 64'd1);
      end
    join
    drain("drain_backpressure");
    chk("bp_retired_count", 64'(retired - base), 64'd4);

    // Reset with two operations in flight.
    @(negedge clk);
    out_ready = 1'b0;
    send(2'd0, 32'd3, 32'd5, 5'd10, 32'd15);
    send(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, pick(32'hFFFFFFFE, 32'h00000001));
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1 if (out_valid) seen++;
    end
    chk("rst_no_stale", 64'(seen), 64'd0);

    send(2'd3, 32'h00010000, 32'h00010000, 5'd12, pick(32'h00000001, 32'h00000000));
    idle();
    drain("drain_after_reset");
    chk("retired_total", 64'(retired), 64'(1 + (NV - 1) + 4 + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
